gpu_rect_fill: RTL and testbench



---
 rtl/gpu_pkg.sv | 40 ++++
 rtl/gpu_rect_fill_if.sv | 28 ++
 rtl/gpu_rect_fill_cursor.sv | 57 +++++
 rtl/gpu_rect_fill.sv | 125 ++++++++++++
 tb/tb_gpu_rect_fill.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared constants, register map and types for the GPU rectangle-fill engine.
// Coordinates are packed {y,x} so a point doubles as a VRAM address.
package gpu_pkg;

  localparam int H_RES   = 160;
  localparam int V_RES   = 120;
  localparam int XW      = 8;
  localparam int YW      = 7;
  localparam int DW      = 8;
  localparam int VRAM_AW = XW + YW;

  localparam logic [1:0] REG_P0    = 2'd0;
  localparam logic [1:0] REG_P1    = 2'd1;
  localparam logic [1:0] REG_COLOR = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } fill_state_t;

  typedef struct packed {
    logic [YW-1:0] y;
    logic [XW-1:0] x;
  } point_t;

  // Pull a point back onto the visible screen so the cursor never walks off-screen.
  function automatic point_t clip_point(input point_t p);
    point_t c;
    c = p;
    if (p.x > XW'(H_RES - 1)) c.x = XW'(H_RES - 1);
    if (p.y > YW'(V_RES - 1)) c.y = YW'(V_RES - 1);
    return c;
  endfunction

endpackage

// File: rtl/gpu_rect_fill_if.sv
// Bus bundle between the I/O decoder / passthrough source and the fill engine,
// including the VRAM write stream and status the engine drives back.
interface gpu_rect_fill_if;
  import gpu_pkg::*;

  logic               cfg_we;
  logic [1:0]         cfg_sel;
  logic [31:0]        cfg_data;
  logic               px_we_i;
  logic [VRAM_AW-1:0] px_addr_i;
  logic [DW-1:0]      px_data_i;
  logic               v_we_o;
  logic [VRAM_AW-1:0] v_addr_o;
  logic [DW-1:0]      v_data_o;
  logic               busy_o;
  logic               done_o;

  modport master (
    output cfg_we, cfg_sel, cfg_data, px_we_i, px_addr_i, px_data_i,
    input  v_we_o, v_addr_o, v_data_o, busy_o, done_o
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_data, px_we_i, px_addr_i, px_data_i,
    output v_we_o, v_addr_o, v_data_o, busy_o, done_o
  );

endinterface

// File: rtl/gpu_rect_fill_cursor.sv
// Raster cursor for the fill engine: walks x0..x1 then steps y, and flags the
// final pixel. A load presents the new start point combinationally that same cycle.
module rect_cursor
  import gpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   advance,
  input  point_t lo,
  input  point_t hi,
  output point_t pos_o,
  output logic   last_o
);

  point_t        cur_q;
  point_t        hi_q;
  logic [XW-1:0] x0_q;

  point_t        base;
  point_t        bound;
  point_t        nxt;
  logic [XW-1:0] x0;

  // On a load the bounds come straight from the inputs, so the first pixel can
  // be emitted on the start edge itself.
  always_comb begin
    base  = load ? lo : cur_q;
    bound = load ? hi : hi_q;
    x0    = load ? lo.x : x0_q;
    nxt   = base;
    if (base.x == bound.x) begin
      nxt.x = x0;
      nxt.y = base.y + 1'b1;
    end else begin
      nxt.x = base.x + 1'b1;
    end
  end

  assign pos_o  = base;
  assign last_o = (base == bound);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      hi_q  <= '0;
      x0_q  <= '0;
    end else if (load) begin
      x0_q  <= lo.x;
      hi_q  <= hi;
      cur_q <= advance ? nxt : lo;
    end else if (advance) begin
      cur_q <= nxt;
    end
  end

endmodule

// File: rtl/gpu_rect_fill.sv
// MMIO rectangle-fill engine in front of the VRAM write port. Passthrough
// pixel writes always win; a queued fill uses every otherwise idle cycle.
module gpu_rect_fill
  import gpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  gpu_rect_fill_if.slave  bus
);

  point_t        p0_q;
  point_t        p1_q;
  logic [DW-1:0] color_q;
  logic [DW-1:0] snap_color_q;
  fill_state_t   state_q;

  logic          ctrl_wr;
  logic          start_req;
  logic          abort_req;
  point_t        p0_clip;
  point_t        p1_clip;
  logic          empty_rect;
  logic          load;
  logic          emit;
  point_t        pos;
  logic          last;
  logic [DW-1:0] fill_color;
  logic          unused_cfg;

  assign ctrl_wr    = bus.cfg_we && (bus.cfg_sel == REG_CTRL);
  assign start_req  = ctrl_wr && bus.cfg_data[CTRL_START] && !bus.cfg_data[CTRL_ABORT];
  assign abort_req  = ctrl_wr && bus.cfg_data[CTRL_ABORT];
  assign p0_clip    = clip_point(p0_q);
  assign p1_clip    = clip_point(p1_q);
  assign empty_rect = (p0_clip.x > p1_clip.x) || (p0_clip.y > p1_clip.y);
  assign load       = (state_q == ST_IDLE) && start_req && !empty_rect;
  assign emit       = !bus.px_we_i && (load || ((state_q == ST_FILL) && !abort_req));
  assign fill_color = load ? color_q : snap_color_q;
  assign unused_cfg = ^bus.cfg_data[31:VRAM_AW];

  rect_cursor u_cursor (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .advance (emit),
    .lo      (p0_clip),
    .hi      (p1_clip),
    .pos_o   (pos),
    .last_o  (last)
  );

  // Programming registers stay writable during a fill; the fill runs from its snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_q    <= '0;
      p1_q    <= '0;
      color_q <= '0;
    end else if (bus.cfg_we) begin
      case (bus.cfg_sel)
        REG_P0:    p0_q    <= point_t'(bus.cfg_data[VRAM_AW-1:0]);
        REG_P1:    p1_q    <= point_t'(bus.cfg_data[VRAM_AW-1:0]);
        REG_COLOR: color_q <= bus.cfg_data[DW-1:0];
        default:   ;
      endcase
    end
  end

  // done_o is raised together with the final pixel write, marking the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      snap_color_q <= '0;
      bus.v_we_o   <= 1'b0;
      bus.v_addr_o <= '0;
      bus.v_data_o <= '0;
      bus.busy_o   <= 1'b0;
      bus.done_o   <= 1'b0;
    end else begin
      bus.v_we_o <= 1'b0;
      bus.done_o <= 1'b0;
      if (bus.px_we_i) begin
        bus.v_we_o   <= 1'b1;
        bus.v_addr_o <= bus.px_addr_i;
        bus.v_data_o <= bus.px_data_i;
      end else if (emit) begin
        bus.v_we_o   <= 1'b1;
        bus.v_addr_o <= pos;
        bus.v_data_o <= fill_color;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            snap_color_q <= color_q;
            bus.busy_o   <= 1'b1;
            if (empty_rect || (emit && last)) begin
              state_q    <= ST_DONE;
              bus.done_o <= 1'b1;
            end else begin
              state_q <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (abort_req) begin
            state_q    <= ST_IDLE;
            bus.busy_o <= 1'b0;
          end else if (emit && last) begin
            state_q    <= ST_DONE;
            bus.done_o <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          bus.busy_o <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          bus.busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Directed bench for gpu_rect_fill: a pixel-list model predicts every output cycle,
// and literal expectations per scenario pin the model down.
module tb_gpu_rect_fill;
  import gpu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  gpu_rect_fill_if bus ();

  gpu_rect_fill u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int start_cyc = 0;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t log_q[$];
  int  done_cnt = 0;
  int  done_cyc = -1;

  logic [14:0] m_p0 = '0;
  logic [14:0] m_p1 = '0;
  logic [7:0]  m_color = '0;
  logic [7:0]  m_snap = '0;
  int          m_q[$];
  logic        exp_we = 1'b0;
  logic [14:0] exp_addr = '0;
  logic [7:0]  exp_data = '0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a started fill becomes the list of pixels it must write; one pops per free cycle.
  always @(posedge clk or negedge rst_n) begin : model
    bit was_done, ctrl, start, abort;
    int x0, x1, y0, y1;
    if (!rst_n) begin
      m_q.delete();
      m_p0 = '0; m_p1 = '0; m_color = '0; m_snap = '0;
      exp_we = 0; exp_addr = '0; exp_data = '0; exp_busy = 0; exp_done = 0;
    end else begin
      was_done = exp_done;
      ctrl  = bus.cfg_we && (bus.cfg_sel == 2'd3);
      start = ctrl && bus.cfg_data[0] && !bus.cfg_data[1];
      abort = ctrl && bus.cfg_data[1];
      exp_we = 0;
      exp_done = 0;
      if (bus.px_we_i) begin
        exp_we = 1; exp_addr = bus.px_addr_i; exp_data = bus.px_data_i;
      end
      if (m_q.size() > 0) begin
        if (abort) m_q.delete();
        else if (!bus.px_we_i) begin
          exp_we = 1; exp_addr = 15'(m_q.pop_front()); exp_data = m_snap;
          if (m_q.size() == 0) exp_done = 1;
        end
      end else if (!was_done && start) begin
        x0 = (m_p0[7:0] > 159) ? 159 : int'(m_p0[7:0]);
        y0 = (m_p0[14:8] > 119) ? 119 : int'(m_p0[14:8]);
        x1 = (m_p1[7:0] > 159) ? 159 : int'(m_p1[7:0]);
        y1 = (m_p1[14:8] > 119) ? 119 : int'(m_p1[14:8]);
        m_snap = m_color;
        for (int y = y0; y <= y1; y++)
          for (int x = x0; x <= x1; x++)
            m_q.push_back(y * 256 + x);
        if (m_q.size() == 0) exp_done = 1;
        else if (!bus.px_we_i) begin
          exp_we = 1; exp_addr = 15'(m_q.pop_front()); exp_data = m_snap;
          if (m_q.size() == 0) exp_done = 1;
        end
      end
      if (bus.cfg_we) begin
        case (bus.cfg_sel)
          2'd0: m_p0 = bus.cfg_data[14:0];
          2'd1: m_p1 = bus.cfg_data[14:0];
          2'd2: m_color = bus.cfg_data[7:0];
          default: ;
        endcase
      end
      exp_busy = (m_q.size() > 0) || exp_done;
    end
  end

  always @(negedge clk) begin
    check_output("v_we", int'(bus.v_we_o), int'(exp_we));
    check_output("busy", int'(bus.busy_o), int'(exp_busy));
    check_output("done", int'(bus.done_o), int'(exp_done));
    if (exp_we) begin
      check_output("v_addr", int'(bus.v_addr_o), int'(exp_addr));
      check_output("v_data", int'(bus.v_data_o), int'(exp_data));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.v_we_o) log_q.push_back('{cyc, int'(bus.v_addr_o), int'(bus.v_data_o)});
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] sel, input logic [31:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_data = data;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic program_regs(input int p0, input int p1, input int color);
    apply_stimulus(REG_P0, p0);
    apply_stimulus(REG_P1, p1);
    apply_stimulus(REG_COLOR, color);
  endtask

  task automatic start_fill();
    log_q.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    start_cyc = cyc + 1;
    apply_stimulus(REG_CTRL, 32'h1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.busy_o && n < budget) begin
      tick();
      n++;
    end
    check_output({tag, "_idle"}, int'(bus.busy_o), 0);
    repeat (2) tick();
  endtask

  task automatic check_wr(input string tag, input int idx, input int addr, input int data, input int at);
    if (idx < log_q.size()) begin
      check_output({tag, "_addr"}, log_q[idx].addr, addr);
      check_output({tag, "_data"}, log_q[idx].data, data);
      check_output({tag, "_cyc"}, log_q[idx].cyc - start_cyc, at);
    end else begin
      check_output({tag, "_missing"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_sel = '0; bus.cfg_data = '0;
    bus.px_we_i = 0; bus.px_addr_i = '0; bus.px_data_i = '0;
    repeat (2) tick();
    check_output("rst_v_we", int'(bus.v_we_o), 0);
    check_output("rst_busy", int'(bus.busy_o), 0);
    check_output("rst_done", int'(bus.done_o), 0);
    check_output("rst_addr", int'(bus.v_addr_o), 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] 2x2 fill");
    program_regs(32'h0305, 32'h0406, 32'h1C);
    start_fill();
    wait_idle("fill2x2", 20);
    check_output("fill2x2_count", log_q.size(), 4);
    check_wr("fill2x2_w0", 0, 16'h0305, 8'h1C, 0);
    check_wr("fill2x2_w1", 1, 16'h0306, 8'h1C, 1);
    check_wr("fill2x2_w2", 2, 16'h0405, 8'h1C, 2);
    check_wr("fill2x2_w3", 3, 16'h0406, 8'h1C, 3);
    check_output("fill2x2_done_cnt", done_cnt, 1);
    check_output("fill2x2_done_cyc", done_cyc - start_cyc, 3);

    $display("[TB] single pixel");
    program_regs(32'h0000, 32'h0000, 32'hFF);
    start_fill();
    wait_idle("single", 10);
    check_output("single_count", log_q.size(), 1);
    check_wr("single_w0", 0, 16'h0000, 8'hFF, 0);
    check_output("single_done_cnt", done_cnt, 1);

    $display("[TB] inverted x");
    program_regs(32'h000A, 32'h0009, 32'h11);
    start_fill();
    wait_idle("inverted", 10);
    check_output("inverted_count", log_q.size(), 0);
    check_output("inverted_done_cnt", done_cnt, 1);
    check_output("inverted_done_cyc", done_cyc - start_cyc, 0);

    $display("[TB] clipping");
    program_regs(32'h009E, 32'h00FF, 32'h3C);
    start_fill();
    wait_idle("clip_x", 10);
    check_output("clip_x_count", log_q.size(), 2);
    check_wr("clip_x_w0", 0, 16'h009E, 8'h3C, 0);
    check_wr("clip_x_w1", 1, 16'h009F, 8'h3C, 1);
    program_regs(32'h769F, 32'h7FFF, 32'h3D);
    start_fill();
    wait_idle("clip_y", 10);
    check_output("clip_y_count", log_q.size(), 2);
    check_wr("clip_y_w0", 0, 16'h769F, 8'h3D, 0);
    check_wr("clip_y_w1", 1, 16'h779F, 8'h3D, 1);

    $display("[TB] passthrough collision");
    program_regs(32'h020A, 32'h020D, 32'h99);
    start_fill();
    bus.px_we_i = 1; bus.px_addr_i = 15'h1234; bus.px_data_i = 8'h55;
    tick();
    bus.px_we_i = 0;
    wait_idle("collide", 20);
    check_output("collide_count", log_q.size(), 5);
    check_wr("collide_w0", 0, 16'h020A, 8'h99, 0);
    check_wr("collide_px", 1, 16'h1234, 8'h55, 1);
    check_wr("collide_w1", 2, 16'h020B, 8'h99, 2);
    check_wr("collide_w3", 4, 16'h020D, 8'h99, 4);
    check_output("collide_done_cyc", done_cyc - start_cyc, 4);

    $display("[TB] passthrough on the start edge of a 1x1 fill");
    program_regs(32'h0707, 32'h0707, 32'h21);
    bus.px_we_i = 1; bus.px_addr_i = 15'h0ABC; bus.px_data_i = 8'h66;
    start_fill();
    bus.px_we_i = 0;
    wait_idle("last_px", 10);
    check_wr("last_px_px", 0, 16'h0ABC, 8'h66, 0);
    check_wr("last_px_w0", 1, 16'h0707, 8'h21, 1);
    check_output("last_px_done_cyc", done_cyc - start_cyc, 1);

    $display("[TB] abort");
    program_regs(32'h0000, 32'h0909, 32'h42);
    start_fill();
    tick();
    apply_stimulus(REG_CTRL, 32'h2);
    wait_idle("abort", 10);
    check_output("abort_count", log_q.size(), 2);
    check_output("abort_done_cnt", done_cnt, 0);

    log_q.delete();
    done_cnt = 0;
    apply_stimulus(REG_CTRL, 32'h3);
    repeat (3) tick();
    check_output("start_abort_count", log_q.size(), 0);
    check_output("start_abort_done_cnt", done_cnt, 0);

    $display("[TB] reset mid-fill");
    start_fill();
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_v_we", int'(bus.v_we_o), 0);
    check_output("midrst_busy", int'(bus.busy_o), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_output("midrst_done_cnt", done_cnt, 0);
    start_fill();
    wait_idle("postrst_cleared", 10);
    check_output("postrst_cleared_count", log_q.size(), 1);
    check_wr("postrst_cleared_w0", 0, 16'h0000, 8'h00, 0);
    program_regs(32'h0514, 32'h0516, 32'hA5);
    start_fill();
    wait_idle("postrst", 10);
    check_output("postrst_count", log_q.size(), 3);
    check_wr("postrst_w2", 2, 16'h0516, 8'hA5, 2);

    $display("[TB] restart while busy");
    program_regs(32'h0101, 32'h0203, 32'h33);
    start_fill();
    apply_stimulus(REG_COLOR, 32'h77);
    apply_stimulus(REG_CTRL, 32'h1);
    wait_idle("restart", 20);
    check_output("restart_count", log_q.size(), 6);
    check_wr("restart_w5", 5, 16'h0203, 8'h33, 5);
    check_output("restart_done_cnt", done_cnt, 1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
